// File: rtl/mc_controller_hs_if.sv
// Handshake bundle between the multicycle control FSM and its datapath/IR/memory.
// The master side is the controller; the slave side is the datapath that owns IR and memory.
interface mc_controller_hs_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             ext_op;
  logic             lui_op;
  logic             pc_or_data;
  logic [1:0]       reg_dst;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [3:0]       alu_op;
  logic [3:0]       state;
  logic             trap;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, ext_op, lui_op, pc_or_data, reg_dst, alu_src_a, alu_src_b,
           pc_source, alu_op, state, trap, mem_timeout_err, retired
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, ext_op, lui_op, pc_or_data, reg_dst, alu_src_a, alu_src_b,
           pc_source, alu_op, state, trap, mem_timeout_err, retired
  );
endinterface

// File: rtl/mc_controller_hs.sv
// Multicycle CPU control FSM: memory-ready handshake, wait timeout trap, illegal-op trap
// and a retired-instruction counter.
module mc_controller_hs #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic                clk,
  input  logic                reset,
  mc_controller_hs_if.master  bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX     = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_ALU = 4'd6,
    S_JR     = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_JR, C_JALR, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_IALU, C_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic       pc_or_data;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       trap;
  } ctrl_t;

  // The wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_next;
  op_class_t        op_class;
  logic [WAIT_W-1:0] wait_cnt;
  logic             mem_state;
  logic             timeout_hit;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  logic             err_q;
  ctrl_t            ctl;

  always_comb begin
    op_class = C_ILLEGAL;
    case (bus.opcode)
      6'h00: begin
        if (bus.funct == 6'h08)      op_class = C_JR;
        else if (bus.funct == 6'h09) op_class = C_JALR;
        else                         op_class = C_RALU;
      end
      6'h23: op_class = C_LW;
      6'h2b: op_class = C_SW;
      6'h04: op_class = C_BEQ;
      6'h02: op_class = C_J;
      6'h03: op_class = C_JAL;
      6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b: op_class = C_IALU;
      default: op_class = C_ILLEGAL;
    endcase
  end

  assign mem_state = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // NOTE: every variable written in a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    if (mem_state && !bus.mem_ready) begin
      // A stalled access holds its state; ready on the last allowed cycle wins over timeout.
      if ((MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LAST)) begin
        state_next  = S_TRAP;
        timeout_hit = 1'b1;
      end
    end else begin
      case (state)
        S_IF:     state_next = S_ID;
        S_ID: begin
          if (op_class != C_ILLEGAL) state_next = S_EX;
          else if (TRAP_ON_ILLEGAL)  state_next = S_TRAP;
          else                       state_next = S_IF;
        end
        S_EX: begin
          case (op_class)
            C_LW:           state_next = S_MEM_RD;
            C_SW:           state_next = S_MEM_WR;
            C_RALU, C_IALU: state_next = S_WB_ALU;
            C_JR, C_JALR:   state_next = S_JR;
            default:        state_next = S_IF;
          endcase
        end
        S_MEM_RD: state_next = S_WB_MEM;
        S_MEM_WR, S_WB_MEM, S_WB_ALU, S_JR: state_next = S_IF;
        default:  state_next = state;
      endcase
    end
  end

  assign retire = (state_next == S_IF) && (state != S_IF) && (state != S_TRAP);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IF;
      wait_cnt  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_state && !bus.mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  // Outputs are forced to zero while reset is held, even though state already reads IF.
  always_comb begin
    ctl = '0;
    if (!reset) begin
      ctl.ext_op    = (bus.opcode != 6'h0c);
      ctl.lui_op    = (bus.opcode == 6'h0f);
      ctl.alu_op[3] = bus.opcode[0];
      if (state != S_IF && state != S_ID) begin
        case (bus.opcode)
          6'h00:        ctl.alu_op[2:0] = 3'b010;
          6'h04:        ctl.alu_op[2:0] = 3'b001;
          6'h0c:        ctl.alu_op[2:0] = 3'b100;
          6'h0a, 6'h0b: ctl.alu_op[2:0] = 3'b101;
          default:      ctl.alu_op[2:0] = 3'b000;
        endcase
      end
      case (state)
        S_IF: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = 2'b01;
          ctl.ir_write  = bus.mem_ready;
          ctl.pc_write  = bus.mem_ready;
        end
        S_ID: ctl.alu_src_b = 2'b11;
        S_EX: begin
          case (op_class)
            C_LW, C_SW, C_IALU: begin
              ctl.alu_src_a = 2'b01;
              ctl.alu_src_b = 2'b10;
            end
            C_BEQ: begin
              ctl.alu_src_a     = 2'b01;
              ctl.pc_write_cond = 1'b1;
              ctl.pc_source     = 2'b01;
            end
            C_J: begin
              ctl.pc_write  = 1'b1;
              ctl.pc_source = 2'b11;
            end
            C_JAL: begin
              ctl.pc_write   = 1'b1;
              ctl.pc_source  = 2'b11;
              ctl.reg_write  = 1'b1;
              ctl.reg_dst    = 2'b10;
              ctl.pc_or_data = 1'b1;
            end
            C_RALU, C_JR, C_JALR: begin
              // Shifts take the shamt path on ALU input A.
              ctl.alu_src_a = (bus.funct == 6'h00 || bus.funct == 6'h02 || bus.funct == 6'h03)
                              ? 2'b10 : 2'b01;
            end
            default: ;
          endcase
        end
        S_MEM_RD: begin
          ctl.mem_read  = 1'b1;
          ctl.iord      = 1'b1;
          ctl.alu_src_a = 2'b01;
          ctl.alu_src_b = 2'b10;
        end
        S_WB_MEM: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          ctl.mem_write = 1'b1;
          ctl.iord      = 1'b1;
          ctl.alu_src_a = 2'b01;
          ctl.alu_src_b = 2'b10;
        end
        S_WB_ALU: begin
          ctl.reg_write = 1'b1;
          ctl.reg_dst   = (bus.opcode == 6'h00) ? 2'b01 : 2'b00;
        end
        S_JR: begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = 2'b01;
          if (op_class == C_JALR) begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = 2'b01;
            ctl.pc_or_data = 1'b1;
          end
        end
        S_TRAP:  ctl.trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_write        = ctl.pc_write;
  assign bus.pc_write_cond   = ctl.pc_write_cond;
  assign bus.iord            = ctl.iord;
  assign bus.mem_read        = ctl.mem_read;
  assign bus.mem_write       = ctl.mem_write;
  assign bus.ir_write        = ctl.ir_write;
  assign bus.mem_to_reg      = ctl.mem_to_reg;
  assign bus.reg_write       = ctl.reg_write;
  assign bus.ext_op          = ctl.ext_op;
  assign bus.lui_op          = ctl.lui_op;
  assign bus.pc_or_data      = ctl.pc_or_data;
  assign bus.reg_dst         = ctl.reg_dst;
  assign bus.alu_src_a       = ctl.alu_src_a;
  assign bus.alu_src_b       = ctl.alu_src_b;
  assign bus.pc_source       = ctl.pc_source;
  assign bus.alu_op          = ctl.alu_op;
  assign bus.trap            = ctl.trap;
  assign bus.state           = state;
  assign bus.mem_timeout_err = err_q;
  assign bus.retired         = retired_q;

endmodule
